// File: rtl/qcw_gate_deadtime.sv
// qcw_gate_deadtime
// Gate-drive output stage for the two half-bridge legs of the QCW driver.
// Each leg turns a 1-bit side command into registered P/N gate signals. It
// enforces a both-off dead interval on every transition and a minimum on-time
// per side. Any kill condition forces all-off at once. A halt sets a latched
// fault that keeps every gate off until firmware clears it.
module qcw_gate_deadtime #(
  parameter int DEADTIME_CYCLES = 8,
  parameter int MIN_ON_CYCLES   = 16,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic in_A,
  input  logic in_B,
  input  logic out_enable,
  input  logic halt,
  input  logic fault_clr,
  output logic gate1_p,
  output logic gate1_n,
  output logic gate2_p,
  output logic gate2_n,
  output logic fault,
  output logic active
);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_DT,
    ST_ONP,
    ST_ONN
  } legState_t;

  localparam logic [CNT_W-1:0] DT_LOAD  = CNT_W'(DEADTIME_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_LOAD = CNT_W'(MIN_ON_CYCLES - 1);

  // Index 0 is leg 1 (in_A), index 1 is leg 2 (in_B).
  legState_t        r_state     [2];
  legState_t        w_stateNext [2];
  logic [CNT_W-1:0] r_cnt       [2];
  logic [CNT_W-1:0] w_cntNext   [2];
  logic [1:0]       r_tgt;
  logic [1:0]       w_tgtNext;
  logic [1:0]       r_gateP;
  logic [1:0]       r_gateN;
  logic [1:0]       w_gatePNext;
  logic [1:0]       w_gateNNext;
  logic [1:0]       w_cmd;
  logic             r_fault;
  logic             w_faultNext;
  logic             r_active;
  logic             w_activeNext;
  logic             w_kill;

  assign w_cmd = {in_B, in_A};

  // State register: leg FSMs, counters, targets, registered gates and status.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state[0] <= ST_OFF;
      r_state[1] <= ST_OFF;
      r_cnt[0]   <= '0;
      r_cnt[1]   <= '0;
      r_tgt      <= '0;
      r_gateP    <= '0;
      r_gateN    <= '0;
      r_fault    <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_state[0] <= w_stateNext[0];
      r_state[1] <= w_stateNext[1];
      r_cnt[0]   <= w_cntNext[0];
      r_cnt[1]   <= w_cntNext[1];
      r_tgt      <= w_tgtNext;
      r_gateP    <= w_gatePNext;
      r_gateN    <= w_gateNNext;
      r_fault    <= w_faultNext;
      r_active   <= w_activeNext;
    end
  end

  // Next-state logic: fault latch plus the dead-time/min-on sequencing per leg.
  always_comb begin
    w_kill      = ~out_enable | halt | r_fault;
    w_faultNext = r_fault;
    w_tgtNext   = r_tgt;
    if (halt) begin
      w_faultNext = 1'b1;
    end else if (fault_clr) begin
      w_faultNext = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      w_stateNext[i] = r_state[i];
      w_cntNext[i]   = r_cnt[i];
      if (w_kill) begin
        w_stateNext[i] = ST_OFF;
        w_cntNext[i]   = '0;
      end else begin
        case (r_state[i])
          ST_OFF: begin
            w_stateNext[i] = ST_DT;
            w_cntNext[i]   = DT_LOAD;
            w_tgtNext[i]   = w_cmd[i];
          end
          ST_DT: begin
            // The target tracks the command during dead time. The side that
            // turns on is the one last seen before the count expires.
            w_tgtNext[i] = w_cmd[i];
            if (r_cnt[i] == '0) begin
              w_stateNext[i] = r_tgt[i] ? ST_ONP : ST_ONN;
              w_cntNext[i]   = MIN_LOAD;
            end else begin
              w_cntNext[i] = r_cnt[i] - CNT_W'(1);
            end
          end
          ST_ONP, ST_ONN: begin
            // A side change is only honoured once the min-on count has run out.
            // A command that reverted before then is simply never seen.
            if ((w_cmd[i] != (r_state[i] == ST_ONP)) && (r_cnt[i] == '0)) begin
              w_stateNext[i] = ST_DT;
              w_cntNext[i]   = DT_LOAD;
              w_tgtNext[i]   = w_cmd[i];
            end else if (r_cnt[i] != '0) begin
              w_cntNext[i] = r_cnt[i] - CNT_W'(1);
            end
          end
          default: begin
            w_stateNext[i] = ST_OFF;
            w_cntNext[i]   = '0;
          end
        endcase
      end
    end
  end

  // Output decode from the next state, so the gates register in step with the FSM.
  always_comb begin
    w_gatePNext = '0;
    w_gateNNext = '0;
    for (int i = 0; i < 2; i++) begin
      w_gatePNext[i] = (w_stateNext[i] == ST_ONP);
      w_gateNNext[i] = (w_stateNext[i] == ST_ONN);
    end
    w_activeNext = (w_stateNext[0] != ST_OFF) | (w_stateNext[1] != ST_OFF);
  end

  assign gate1_p = r_gateP[0];
  assign gate1_n = r_gateN[0];
  assign gate2_p = r_gateP[1];
  assign gate2_n = r_gateN[1];
  assign fault   = r_fault;
  assign active  = r_active;

endmodule
